rgb_fade_controller: RTL and testbench
======================================

# rgb_fade_controller

Parametrised multi-channel LED intensity controller with per-channel PWM generation and linear fading. It replaces the fixed three-channel, instant-update RGB path. Host logic writes a target intensity per channel. Each channel then either jumps to that target or ramps to it one LSB per ramp tick. Duty changes are applied only at PWM period boundaries, so outputs never glitch.

## Interface
- `N_CH`, 3, number of LED channels (≥1)
- `R`, 8, intensity MSB index; intensity and duty are R+1 bits; PWM period is 2^(R+1) clocks
- `RAMP_DIV`, 1024, clocks per ramp tick (≥1)
- `clk` input 1 system clock, rising edge
- `reset` input 1 asynchronous, active-low reset
- `load` input 1 one-cycle strobe: write `intensity` as target of channel `ch_sel`
- `ch_sel` input CSW channel index, where CSW = max(1, clog2(N_CH))
- `intensity` input R+1 target intensity
- `fade_en` input 1 sampled with `load`: 1 = ramp to target, 0 = jump to target
- `busy` output 1 high while any channel's current duty ≠ its target
- `pwm_out` output N_CH registered PWM outputs, bit i drives channel i

## Operation
- Per-channel registers, each R+1 bits:
  - `target[i]`: requested intensity.
  - `current[i]`: live ramp value.
  - `shadow[i]`: duty used by the comparator.
- **Load**:
  - With `load`=1 and `ch_sel` < N_CH: `target[ch_sel]` ← `intensity`.
  - If `fade_en`=0, `current[ch_sel]` ← `intensity` in the same cycle.
  - If `ch_sel` ≥ N_CH, the write is silently ignored.
- **Ramp prescaler**:
  - Counts 0..RAMP_DIV-1 and wraps.
  - `tick` is high for one cycle when count = RAMP_DIV-1.
  - RAMP_DIV=1 means a tick every cycle.
- **Per-channel ramp state**, derived each cycle:
  - IDLE when `current`=`target`.
  - UP when `current`<`target`.
  - DOWN when `current`>`target`.
  - On `tick`: UP → `current`+1, DOWN → `current`-1, IDLE → hold.
  - No wrap-around: `current` never passes `target`.
- **Simultaneous load and tick on the same channel**:
  - `fade_en`=0: the load wins and `current` = `intensity`.
  - `fade_en`=1: the step is computed against the old target; the new target governs from the next tick.
- **PWM**:
  - A shared free-running counter `cnt` (R+1 bits) counts 0..2^(R+1)-1 and wraps.
  - When `cnt` = all-ones, every `shadow[i]` ← `current[i]`.
  - `pwm_out[i]` is registered as (`cnt` < `shadow[i]`).
  - Duty 0 gives a constant low output. Duty all-ones gives high for 2^(R+1)-1 of every 2^(R+1) clocks.
- `busy` = OR over channels of (`current`≠`target`), registered.
- **Reset** (asynchronous, active-low): all targets, currents, shadows, `cnt`, prescaler, `busy` and `pwm_out` go to 0. Reset asserted mid-fade abandons the fade; nothing resumes after release.

## Timing
- `load` at edge t with `fade_en`=0 → `current` updates at t+1.
- `shadow` takes that value at the next cycle where `cnt` = all-ones.
- `pwm_out` reflects the new duty starting one cycle after the wrap (one cycle of comparator register latency).
- Fade duration = |Δ| × RAMP_DIV clocks, ±1 tick of prescaler phase. The prescaler is free-running and is not restarted by `load`.
- `busy` rises one cycle after the `load` that creates a mismatch. It falls one cycle after the tick that makes all channels equal.
- After reset release, `cnt` and the prescaler start from 0 on the first rising edge.
- No back-pressure: `load` may be asserted every cycle, and the last write to a channel wins.

## Structure
- Shared package `rgb_led_pkg` holds:
  - the CSW width function (clog2 with minimum 1);
  - ramp state encoding IDLE=2'b00, UP=2'b01, DOWN=2'b10;
  - default values of N_CH, R and RAMP_DIV.
- Sub-module `pwm_channel` (parameter R) contains:
  - the `target`, `current` and `shadow` registers;
  - the ramp step logic;
  - the comparator output register.
- `pwm_channel` takes shared `cnt`, `tick` and `wrap` from the top level, and is instantiated N_CH times with generate.
- The top level owns `cnt`, the prescaler, load decode and the `busy` reduction.

## Test plan
All scenarios use N_CH=3, R=3 (period 16), RAMP_DIV=4.
- **Reset**: hold `reset`=0 for 5 cycles with `load` toggling → `pwm_out`=3'b000, `busy`=0; after release, `pwm_out` stays 0 for 32 cycles.
- **Immediate load**: `load` ch0=8 with `fade_en`=0 → after the next `cnt` wrap, `pwm_out[0]` is high exactly 8 of 16 cycles; `busy` stays 0.
- **Fade up**: `load` ch1=5 with `fade_en`=1 from 0 → `busy`=1; `current[1]` steps 1,2,3,4,5, one step every 4 cycles; `busy` falls within 21 cycles.
- **Retarget**: fade ch2 to 12, then at `current`=6 `load` ch2=2 with `fade_en`=1 → the ramp reverses and reaches 2 after 4 further ticks. Also: `load` and `tick` in the same cycle with `fade_en`=0 → `current` equals the loaded value.
- **Invalid channel**: `load` with `ch_sel`=3 and `intensity`=15 → no register changes and `busy` stays 0.
- **Reset mid-fade**: assert reset during a 0→15 fade on ch0 → all outputs 0 immediately (asynchronous); after release, ch0 stays at 0.

Source files
------------

// File: rtl/rgb_led_pkg.sv
// Shared definitions for the multi-channel LED fade controller: default sizing,
// ramp direction encoding and the channel-select width helper.
package rgb_led_pkg;

    localparam int unsigned DefNCh     = 3;
    localparam int unsigned DefR       = 8;
    localparam int unsigned DefRampDiv = 1024;

    typedef enum logic [1:0] {
        RampIdle = 2'b00,
        RampUp   = 2'b01,
        RampDown = 2'b10
    } ramp_state_e;

    // clog2 that never returns 0, so a one-entry select still has a real bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: target/current/shadow duty registers, linear ramp stepping
// and the registered PWM comparator.
module pwm_channel
    import rgb_led_pkg::*;
#(
    parameter int unsigned R = DefR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         fade_en,
    input  logic [R:0]   intensity,
    input  logic [R:0]   cnt,
    input  logic         tick,
    input  logic         wrap,
    output logic         pwm,
    output logic         mismatch
);

    logic [R:0]  target;
    logic [R:0]  current;
    logic [R:0]  shadow;
    logic [R:0]  current_next;
    ramp_state_e state;

    always_comb begin
        state = RampIdle;
        if (current < target) begin
            state = RampUp;
        end else if (current > target) begin
            state = RampDown;
        end
    end

    // A jump load overrides any ramp step; a fade load leaves this cycle's step
    // governed by the old target.
    always_comb begin
        current_next = current;
        if (load && !fade_en) begin
            current_next = intensity;
        end else if (tick) begin
            case (state)
                RampUp:   current_next = current + 1'b1;
                RampDown: current_next = current - 1'b1;
                default:  current_next = current;
            endcase
        end
    end

    assign mismatch = (current != target);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target  <= '0;
            current <= '0;
            shadow  <= '0;
            pwm     <= 1'b0;
        end else begin
            if (load) begin
                target <= intensity;
            end
            current <= current_next;
            // Duty only changes at the period boundary so the output never glitches.
            if (wrap) begin
                shadow <= current;
            end
            pwm <= (cnt < shadow);
        end
    end

endmodule

// File: rtl/rgb_fade_controller.sv
// Multi-channel LED intensity controller: shared PWM counter and ramp
// prescaler, load decode, per-channel fade engines and a registered busy flag.
module rgb_fade_controller
    import rgb_led_pkg::*;
#(
    parameter int unsigned N_CH     = DefNCh,
    parameter int unsigned R        = DefR,
    parameter int unsigned RAMP_DIV = DefRampDiv,
    localparam int unsigned CSW     = sel_width(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [CSW-1:0]  ch_sel,
    input  logic [R:0]      intensity,
    input  logic            fade_en,
    output logic            busy,
    output logic [N_CH-1:0] pwm_out
);

    localparam int unsigned PW = sel_width(RAMP_DIV);
    localparam logic [PW-1:0] PreMax = PW'(RAMP_DIV - 1);

    logic [R:0]      cnt;
    logic [PW-1:0]   pre;
    logic            tick;
    logic            wrap;
    logic            load_ok;
    logic [N_CH-1:0] ch_load;
    logic [N_CH-1:0] mismatch;

    assign tick    = (pre == PreMax);
    assign wrap    = &cnt;
    assign load_ok = load && (32'(ch_sel) < N_CH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            pre  <= '0;
            busy <= 1'b0;
        end else begin
            cnt  <= cnt + 1'b1;
            pre  <= tick ? '0 : pre + 1'b1;
            busy <= |mismatch;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign ch_load[i] = load_ok && (32'(ch_sel) == i);

        pwm_channel #(
            .R (R)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .load      (ch_load[i]),
            .fade_en   (fade_en),
            .intensity (intensity),
            .cnt       (cnt),
            .tick      (tick),
            .wrap      (wrap),
            .pwm       (pwm_out[i]),
            .mismatch  (mismatch[i])
        );
    end

endmodule

// File: tb/tb_rgb_fade_controller.sv
// Directed bench for rgb_fade_controller with N_CH=3, R=3, RAMP_DIV=4.
module tb_rgb_fade_controller;

    localparam int unsigned NCh     = 3;
    localparam int unsigned R       = 3;
    localparam int unsigned RampDiv = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           load = 1'b0;
    logic [1:0]     ch_sel = '0;
    logic [R:0]     intensity = '0;
    logic           fade_en = 1'b0;
    logic           busy;
    logic [NCh-1:0] pwm_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_fade_controller #(
        .N_CH     (NCh),
        .R        (R),
        .RAMP_DIV (RampDiv)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .ch_sel    (ch_sel),
        .intensity (intensity),
        .fade_en   (fade_en),
        .busy      (busy),
        .pwm_out   (pwm_out)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [R:0] cur(input int i);
        case (i)
            0:       return dut.g_ch[0].u_chan.current;
            1:       return dut.g_ch[1].u_chan.current;
            default: return dut.g_ch[2].u_chan.current;
        endcase
    endfunction

    function automatic logic [R:0] tgt(input int i);
        case (i)
            0:       return dut.g_ch[0].u_chan.target;
            1:       return dut.g_ch[1].u_chan.target;
            default: return dut.g_ch[2].u_chan.target;
        endcase
    endfunction

    task automatic do_load(input int ch, input int val, input logic fade);
        ch_sel    = 2'(ch);
        intensity = 4'(val);
        fade_en   = fade;
        load      = 1'b1;
        cyc();
        load      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            load = ~load; ch_sel = 2'd0; intensity = 4'd9; fade_en = 1'b0;
            cyc();
            checks++;
            if (pwm_out !== 3'b000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: pwm_out=%b busy=%b, expected 000/0", pwm_out, busy);
            end
        end
        checks++;
        if (cur(0) !== 4'd0) begin
            errors++;
            $display("FAIL reset_current: got %0d expected 0", cur(0));
        end
        load  = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 32; k++) begin
            cyc();
            checks++;
            if (pwm_out !== 3'b000) begin
                errors++;
                $display("FAIL reset_release_pwm: got %b expected 000", pwm_out);
            end
        end
    endtask

    task automatic test_immediate_load();
        int highs;
        do_load(0, 8, 1'b0);
        checks++;
        if (cur(0) !== 4'd8) begin
            errors++;
            $display("FAIL imm_current: got %0d expected 8", cur(0));
        end
        for (int k = 0; k < 20; k++) begin
            cyc();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL imm_busy: got %b expected 0", busy);
            end
        end
        highs = 0;
        for (int k = 0; k < 16; k++) begin
            cyc();
            if (pwm_out[0] === 1'b1) highs++;
            checks++;
            if (pwm_out[2:1] !== 2'b00) begin
                errors++;
                $display("FAIL imm_other_ch: got %b expected 00", pwm_out[2:1]);
            end
        end
        checks++;
        if (highs != 8) begin
            errors++;
            $display("FAIL imm_duty: high %0d of 16 expected 8", highs);
        end
    endtask

    task automatic test_fade_up();
        logic [R:0] prev;
        logic [R:0] v;
        int steps;
        int last;
        int fall;
        prev = 4'd0; steps = 0; last = -1; fall = -1;
        do_load(1, 5, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (k == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL fade_busy_rise: got %b expected 1", busy);
                end
            end
            v = cur(1);
            if (v !== prev) begin
                checks++;
                if (v !== prev + 4'd1) begin
                    errors++;
                    $display("FAIL fade_step_value: got %0d expected %0d", v, prev + 4'd1);
                end
                if (steps > 0) begin
                    checks++;
                    if (k - last != 4) begin
                        errors++;
                        $display("FAIL fade_step_spacing: got %0d cycles expected 4", k - last);
                    end
                end
                last = k;
                steps++;
                prev = v;
            end
            if (k > 1 && busy === 1'b0 && fall < 0) fall = k;
        end
        checks++;
        if (steps != 5 || prev !== 4'd5) begin
            errors++;
            $display("FAIL fade_steps: got %0d steps ending %0d expected 5 ending 5", steps, prev);
        end
        checks++;
        if (fall < 0 || fall > 21) begin
            errors++;
            $display("FAIL fade_busy_fall: fell at cycle %0d expected 1..21", fall);
        end
    endtask

    task automatic test_retarget();
        logic [R:0] prev;
        logic [R:0] v;
        int steps;
        bit found;
        found = 1'b0;
        do_load(2, 12, 1'b1);
        prev = cur(2);
        for (int k = 0; k < 60 && !found; k++) begin
            cyc();
            if (cur(2) !== prev && cur(2) === 4'd6) found = 1'b1;
            prev = cur(2);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL retarget_reach6: current %0d never stepped to 6", cur(2));
        end
        do_load(2, 2, 1'b1);
        checks++;
        if (cur(2) !== 4'd6 || tgt(2) !== 4'd2) begin
            errors++;
            $display("FAIL retarget_load: cur %0d tgt %0d expected 6/2", cur(2), tgt(2));
        end
        prev = 4'd6; steps = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            v = cur(2);
            if (v !== prev) begin
                checks++;
                if (v !== prev - 4'd1) begin
                    errors++;
                    $display("FAIL retarget_step: got %0d expected %0d", v, prev - 4'd1);
                end
                steps++;
                prev = v;
            end
        end
        checks++;
        if (steps != 4 || prev !== 4'd2) begin
            errors++;
            $display("FAIL retarget_end: %0d steps ending %0d expected 4 ending 2", steps, prev);
        end

        // Find the tick phase from a ramp step, then load exactly on a tick.
        do_load(2, 10, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (cur(2) !== 4'd2) found = 1'b1;
            else cyc();
        end
        checks++;
        if (!found || cur(2) !== 4'd3) begin
            errors++;
            $display("FAIL tick_phase_step: got %0d expected 3", cur(2));
        end
        cyc();
        cyc();
        cyc();
        do_load(2, 9, 1'b0);
        checks++;
        if (cur(2) !== 4'd9 || tgt(2) !== 4'd9) begin
            errors++;
            $display("FAIL load_tick_collision: cur %0d tgt %0d expected 9/9", cur(2), tgt(2));
        end
        cyc();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL collision_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_invalid_channel();
        do_load(3, 15, 1'b0);
        checks++;
        if (cur(0) !== 4'd8 || cur(1) !== 4'd5 || cur(2) !== 4'd9 ||
            tgt(0) !== 4'd8 || tgt(1) !== 4'd5 || tgt(2) !== 4'd9) begin
            errors++;
            $display("FAIL invalid_regs: cur %0d/%0d/%0d tgt %0d/%0d/%0d expected 8/5/9 8/5/9",
                     cur(0), cur(1), cur(2), tgt(0), tgt(1), tgt(2));
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL invalid_busy: got %b expected 0", busy);
            end
        end
    endtask

    task automatic test_reset_mid_fade();
        bit found;
        do_load(0, 0, 1'b0);
        repeat (20) cyc();
        do_load(0, 15, 1'b1);
        repeat (10) cyc();
        checks++;
        if (busy !== 1'b1 || cur(0) === 4'd0) begin
            errors++;
            $display("FAIL midfade_active: busy %b cur %0d expected 1 and nonzero", busy, cur(0));
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (pwm_out !== 3'b000) found = 1'b1;
            else cyc();
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 3'b000 || busy !== 1'b0 || cur(0) !== 4'd0 || tgt(0) !== 4'd0 ||
            cur(2) !== 4'd0) begin
            errors++;
            $display("FAIL midfade_async: pwm %b busy %b cur0 %0d tgt0 %0d cur2 %0d expected zeros",
                     pwm_out, busy, cur(0), tgt(0), cur(2));
        end
        cyc();
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cyc();
            checks++;
            if (cur(0) !== 4'd0 || busy !== 1'b0 || pwm_out !== 3'b000) begin
                errors++;
                $display("FAIL midfade_after: cur0 %0d busy %b pwm %b expected 0/0/000",
                         cur(0), busy, pwm_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_immediate_load();
        test_fade_up();
        test_retarget();
        test_invalid_channel();
        test_reset_mid_fade();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
